// File: rtl/rv_muldiv.sv
// Iterative RV32 M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: multiply 2 cycles, divide special case 1 cycle, normal divide 33 cycles.
// Backpressure: ready_o low while busy; no output backpressure, valid_o is a 1-cycle pulse.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i / ready_o       request handshake from decode (accept on valid_i & ready_o)
//   op_i, a_i, b_i          funct3 opcode and rs1/rs2 operands, captured at acceptance
//   kill_i                  pipeline flush, abandons any in-flight operation
//   valid_o, result_o       completion pulse and result (result held until next completion)

package rv_pkg;
  parameter int XLEN = 32;
endpackage

module rv_muldiv #(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [1:0]      op_q;      // op bit 2 is implied by the state we are in
  logic [XLEN:0]   mul_a;     // 33-bit sign-/zero-extended multiply operands
  logic [XLEN:0]   mul_b;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] dvsr_q;
  logic            neg_q;
  logic            neg_r;

  // Decode of the incoming request
  logic            accept;
  logic            op_is_mul;
  logic            div_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            b_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  assign ready_o     = (state == IDLE) & ~kill_i & ~rst_i;
  assign accept      = valid_i & ready_o;
  assign op_is_mul   = ~op_i[2];
  assign div_signed  = ~op_i[0];
  assign a_neg       = div_signed & a_i[XLEN-1];
  assign b_neg       = div_signed & b_i[XLEN-1];
  assign a_abs       = a_neg ? -a_i : a_i;
  assign b_abs       = b_neg ? -b_i : b_i;
  assign b_zero      = (b_i == '0);
  assign div_ovf     = div_signed & (a_i == MIN_NEG) & (b_i == '1);
  // op_i[1] selects remainder; divide-by-zero takes priority over overflow
  assign special_res = b_zero ? (op_i[1] ? a_i : '1)
                              : (op_i[1] ? '0  : MIN_NEG);

  // Multiply: operands are extended to full product width so the low 64 bits
  // of a signed multiply are exact for every signedness combination.
  logic signed [2*XLEN-1:0] mul_ea;
  logic signed [2*XLEN-1:0] mul_eb;
  logic        [2*XLEN-1:0] prod;
  logic        [XLEN-1:0]   mul_res;

  assign mul_ea  = {{(XLEN-1){mul_a[XLEN]}}, mul_a};
  assign mul_eb  = {{(XLEN-1){mul_b[XLEN]}}, mul_b};
  assign prod    = mul_ea * mul_eb;
  assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // One restoring step on {rem, quot}: shift in the next dividend bit, try
  // subtracting the divisor, keep the difference if it did not borrow.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quot_nxt;
  logic [XLEN-1:0] div_res;

  assign shifted  = {rem_q, quot_q[XLEN-1]};
  assign trial    = shifted - {1'b0, dvsr_q};
  assign rem_nxt  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quot_nxt = {quot_q[XLEN-2:0], ~trial[XLEN]};
  assign div_res  = op_q[1] ? (neg_r ? -rem_nxt  : rem_nxt)
                            : (neg_q ? -quot_nxt : quot_nxt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (kill_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              op_q <= op_i[1:0];
              if (op_is_mul) begin
                // MULH and MULHSU sign a; only MULH signs b
                mul_a <= {(op_i == 3'b001 || op_i == 3'b010) & a_i[XLEN-1], a_i};
                mul_b <= {(op_i == 3'b001) & b_i[XLEN-1], b_i};
                state <= MUL;
              end else if (b_zero || div_ovf) begin
                result_o <= special_res;
                valid_o  <= 1'b1;
                state    <= DONE;
              end else begin
                rem_q  <= '0;
                quot_q <= a_abs;
                dvsr_q <= b_abs;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                count  <= CW'(XLEN-1);
                state  <= DIV;
              end
            end
          end
          MUL: begin
            result_o <= mul_res;
            valid_o  <= 1'b1;
            state    <= DONE;
          end
          DIV: begin
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
            count  <= count - 1'b1;
            if (count == '0) begin
              result_o <= div_res;
              valid_o  <= 1'b1;
              state    <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/rv_muldiv.md
# rv_muldiv

Iterative M-extension execution unit for the RV32IM core. It sits in the execute stage beside the ALU: decode issues MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with two XLEN-bit operands, and the unit returns one XLEN-bit result to writeback. Multiplies take a fixed 2 cycles, divides take a 32-step restoring iteration, and divide special cases complete on a fast path. Width comes from `rv_pkg::XLEN`.

## Interface
- `XLEN`, default `rv_pkg::XLEN` (32): operand/result width; only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  operation request from decode.
- `ready_o`  out  1  unit can accept; `= (state==IDLE) & ~kill_i & ~rst_i`.
- `op_i`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a_i`  in  XLEN  rs1 operand (multiplicand / dividend).
- `b_i`  in  XLEN  rs2 operand (multiplier / divisor).
- `kill_i`  in  1  pipeline flush; abandons any in-flight operation.
- `valid_o`  out  1  single-cycle pulse; `result_o` is valid this cycle.
- `result_o`  out  XLEN  operation result; held until the next completion.

## Operation
- Handshake: an operation is accepted in the cycle where `valid_i & ready_o` is high. `op_i`, `a_i` and `b_i` are registered at acceptance and need not be held afterwards. There is no output backpressure; writeback always consumes `valid_o`.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + accept of MUL* -> MUL.
  - IDLE + accept of DIV*/REM* with special case -> DONE.
  - IDLE + accept of other DIV*/REM* -> DIV, with counter = 31.
  - MUL -> DONE.
  - DIV: one restoring step per cycle; counter decrements; when counter==0 -> DONE.
  - DONE -> IDLE. `valid_o` = 1 only in DONE.
- Multiply: form the 64-bit product of 33-bit sign-/zero-extended operands. MULH signs both operands. MULHSU signs `a` and treats `b` as unsigned. MULHU and MUL treat both as unsigned. MUL returns product[31:0]; the others return product[63:32]. The product is registered in the MUL state.
- Divide:
  - Signed ops take absolute values at acceptance.
  - Unsigned core: 32 iterations of shift-subtract on {rem, quot}.
  - On the DIV->DONE transition, the signed quotient is negated if sign(a)^sign(b), and the signed remainder is negated if sign(a).
- Special cases (fast path, no iteration):
  - b==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `a`.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF, DIV/REM only): DIV returns 0x80000000; REM returns 0.
- `result_o` is loaded on entry to DONE and retains its value otherwise.
- kill_i:
  - Synchronous. In any state it forces IDLE at the next edge, and no `valid_o` is produced for the killed operation.
  - kill_i together with valid_i in IDLE: no acceptance, because `ready_o` is 0.
  - kill_i while in DONE: `valid_o` still pulses in that cycle, since the result is already committed.
- Reset: state=IDLE, counter=0, `valid_o`=0, `result_o`=0. `ready_o`=0 while `rst_i` is high and 1 in the first cycle after reset. Reset mid-operation discards the operation with no `valid_o`.

## Timing
- Accept at cycle T; `valid_o` timing:
  - MUL*: `valid_o` at T+2.
  - DIV*/REM* special case: T+1.
  - DIV*/REM* normal: T+33 (32 DIV cycles T+1..T+32, DONE at T+33).
- `ready_o` is low from T+1 through the DONE cycle; next acceptance is no earlier than DONE+1.
- Throughput: 1 multiply per 3 cycles; 1 normal divide per 34 cycles.
- `ready_o` is combinational from state, `kill_i` and `rst_i`. `valid_o` and `result_o` are registered.

## Test plan
- MULH a=0xFFFFFFFF (−1), b=0x00000002 -> `valid_o` at T+2, result 0xFFFFFFFF. MULHU on the same operands -> 0x00000001. MUL -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 -> result 0xFFFFFFFD (−3) at T+33. REM on the same operands -> 0xFFFFFFFF (−1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero:
  - DIVU a=0x12345678, b=0 -> 0xFFFFFFFF at T+1.
  - REM a=0x12345678, b=0 -> 0x12345678.
  - Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Back-to-back: `valid_i` held high with MUL then DIV -> second acceptance in the cycle after the first `valid_o`. `ready_o` is never high while busy. The inputs are changed after acceptance and the result is unaffected.
- Flush: kill_i at T+10 of a DIV -> IDLE at T+11 with `ready_o`=1, no `valid_o`; a new MUL accepted at T+11 returns correctly at T+13. kill_i with valid_i in IDLE -> not accepted.
- Reset: `rst_i` asserted at T+5 of a DIV -> `valid_o`=0 and `result_o`=0 after the edge. `ready_o` is low during reset and high in the cycle after `rst_i` deasserts.
